line_fill_responder: RTL and testbench

Memory-side responder for the 256-bit instruction-cache line-fill protocol. It accepts a line request (address + read strobe held until acknowledge), fetches the eight 32-bit words of the aligned 32-byte line from a word-wide memory bus, and returns the whole line with a one-cycle acknowledge. It reports a hardware page fault for out-of-range addresses or memory errors. It sits between the instruction cache and the system memory bus.

---
 rtl/line_fill_responder_if.sv | 24 ++
 rtl/line_fill_responder.sv | 91 +++++++++
 tb/tb_line_fill_responder.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_fill_responder_if.sv
// Bundles the requester-side line handshake and the word-wide memory bus of the line-fill responder.
// The slave modport is the responder's view; master is the view of whatever drives the requester and memory.
interface line_fill_responder_if;
    logic [31:0]  addr_i;
    logic         rd_i;
    logic [255:0] data_o;
    logic         ack_o;
    logic         hw_page_fault_o;
    logic [31:0]  mem_addr_o;
    logic         mem_rd_o;
    logic [31:0]  mem_data_i;
    logic         mem_ack_i;
    logic         mem_err_i;

    modport slave (
        input  addr_i, rd_i, mem_data_i, mem_ack_i, mem_err_i,
        output data_o, ack_o, hw_page_fault_o, mem_addr_o, mem_rd_o
    );

    modport master (
        output addr_i, rd_i, mem_data_i, mem_ack_i, mem_err_i,
        input  data_o, ack_o, hw_page_fault_o, mem_addr_o, mem_rd_o
    );
endinterface

// File: rtl/line_fill_responder.sv
// Fetches an aligned 32-byte line as eight word reads and returns it with a one-cycle acknowledge,
// flagging a page fault for out-of-range line bases or memory bus errors.
module line_fill_responder #(
    parameter logic [31:0] MEM_LIMIT = 32'h0100_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    line_fill_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FETCH, ACK, GAP} state_t;

    state_t          r_state;
    logic [26:0]     r_line_base;
    logic [2:0]      r_beat;
    logic [7:0][31:0] r_line;
    logic            r_ack;
    logic            r_fault;
    logic            r_mem_rd;
    logic [31:0]     r_mem_addr;
    logic            w_out_of_range;

    assign w_out_of_range = {bus.addr_i[31:5], 5'b0} >= MEM_LIMIT;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_line_base <= '0;
            r_beat      <= '0;
            // NOTE: the line buffer drives data_o directly, so it must be cleared on reset like any output.
            r_line      <= '0;
            r_ack       <= 1'b0;
            r_fault     <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_addr  <= '0;
        end else begin
            // NOTE: ack and fault default low every cycle, so setting them on a transition yields a one-cycle pulse.
            r_ack   <= 1'b0;
            r_fault <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.rd_i) begin
                        r_line_base <= bus.addr_i[31:5];
                        r_beat      <= '0;
                        if (w_out_of_range) begin
                            r_line  <= '0;
                            r_ack   <= 1'b1;
                            r_fault <= 1'b1;
                            r_state <= ACK;
                        end else begin
                            r_mem_rd   <= 1'b1;
                            r_mem_addr <= {bus.addr_i[31:5], 5'b0};
                            r_state    <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (bus.mem_ack_i) begin
                        if (bus.mem_err_i) begin
                            // Remaining beats are abandoned and the partial line never leaves the block.
                            r_mem_rd <= 1'b0;
                            r_line   <= '0;
                            r_ack    <= 1'b1;
                            r_fault  <= 1'b1;
                            r_state  <= ACK;
                        end else begin
                            r_line[r_beat] <= bus.mem_data_i;
                            r_beat         <= r_beat + 3'd1;
                            if (r_beat == 3'd7) begin
                                r_mem_rd <= 1'b0;
                                r_ack    <= 1'b1;
                                r_state  <= ACK;
                            end else begin
                                r_mem_addr <= {r_line_base, r_beat + 3'd1, 2'b00};
                            end
                        end
                    end
                end
                ACK:     r_state <= GAP;
                // The requester's strobe may still be high here; ignoring it prevents a duplicate fill.
                GAP:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.data_o          = r_line;
    assign bus.ack_o           = r_ack;
    assign bus.hw_page_fault_o = r_fault;
    assign bus.mem_rd_o        = r_mem_rd;
    assign bus.mem_addr_o      = r_mem_addr;
endmodule

// File: tb/tb_line_fill_responder.sv
// Self-checking bench for line_fill_responder: a per-cycle timeline model built from the latency rules,
// a reactive memory with configurable wait states and errors, directed scenarios and random requests.
module tb_line_fill_responder;
    localparam logic [31:0] MEM_LIMIT = 32'h0100_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    line_fill_responder_if bus ();

    line_fill_responder #(.MEM_LIMIT(MEM_LIMIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef enum {K_IDLE, K_FETCH, K_ACK, K_RST} kind_t;
    typedef struct {
        kind_t        kind;
        logic [31:0]  addr;
        logic         fault;
        logic [255:0] data;
    } exp_t;
    typedef struct {
        int           lat;
        logic         fault;
        logic [255:0] data;
        int           acks;
        int           strobes;
        int           rds;
    } res_t;

    exp_t         exp_q[$];
    logic [255:0] last_data = '0;
    int           total = 0;
    int           bad = 0;
    int           ack_cnt = 0;
    int           rd_cnt = 0;
    int           strobe_cnt = 0;
    bit           plan_mem = 1'b1;
    int           waits[8];
    bit           err_en = 1'b0;
    int           err_beat = 0;
    int           wait_left = -1;
    logic [31:0]  addr_log[$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (plan_mem) return 32'hA000_0000 + 32'(a[4:2]);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_C3C3;
    endfunction

    // Expected timeline of one request, one entry per sample from the acceptance edge on.
    function automatic void build_fill(input logic [31:0] addr);
        logic [31:0]  base;
        logic [255:0] line;
        bit           fault;
        int           last;
        base  = {addr[31:5], 5'b0};
        line  = '0;
        fault = 1'b0;
        last  = 7;
        exp_q.push_back('{K_IDLE, 32'd0, 1'b0, 256'd0});
        if (base >= MEM_LIMIT) begin
            fault = 1'b1;
        end else begin
            if (err_en) begin
                fault = 1'b1;
                last  = err_beat;
            end
            for (int k = 0; k <= last; k++) begin
                for (int w = 0; w <= waits[k]; w++)
                    exp_q.push_back('{K_FETCH, base + 32'(4 * k), 1'b0, 256'd0});
                line[32 * k +: 32] = mem_word(base + 32'(4 * k));
            end
            if (fault) line = '0;
        end
        exp_q.push_back('{K_ACK, 32'd0, fault, line});
        exp_q.push_back('{K_IDLE, 32'd0, 1'b0, 256'd0});
    endfunction

    always @(negedge clk) begin
        exp_t e;
        e = '{K_IDLE, 32'd0, 1'b0, 256'd0};
        if (exp_q.size() > 0) e = exp_q.pop_front();
        check("mem_rd", bus.mem_rd_o, e.kind == K_FETCH);
        check("ack", bus.ack_o, e.kind == K_ACK);
        check("fault", bus.hw_page_fault_o, e.fault);
        case (e.kind)
            K_FETCH: check("mem_addr", bus.mem_addr_o, e.addr);
            K_ACK: begin
                check("ack_data", bus.data_o, e.data);
                last_data = e.data;
            end
            K_RST: begin
                check("rst_mem_addr", bus.mem_addr_o, 32'd0);
                check("rst_data", bus.data_o, 256'd0);
                last_data = '0;
            end
            default: check("hold_data", bus.data_o, last_data);
        endcase
        if (bus.ack_o) ack_cnt++;
        if (bus.mem_rd_o) rd_cnt++;
        if (bus.mem_rd_o && bus.mem_ack_i) strobe_cnt++;
    end

    // Memory: per-beat wait states, optional error on one beat, noise on unqualified inputs.
    always begin
        @(posedge clk);
        #1;
        if (bus.mem_rd_o === 1'b1) begin
            if (wait_left < 0) wait_left = waits[bus.mem_addr_o[4:2]];
            if (wait_left == 0) begin
                bus.mem_ack_i  = 1'b1;
                bus.mem_data_i = mem_word(bus.mem_addr_o);
                bus.mem_err_i  = err_en && (bus.mem_addr_o[4:2] == 3'(err_beat));
                addr_log.push_back(bus.mem_addr_o);
                wait_left = -1;
            end else begin
                bus.mem_ack_i  = 1'b0;
                bus.mem_data_i = $urandom;
                bus.mem_err_i  = 1'($urandom);
                wait_left--;
            end
        end else begin
            bus.mem_ack_i  = 1'($urandom);
            bus.mem_data_i = $urandom;
            bus.mem_err_i  = 1'($urandom);
            wait_left = -1;
        end
    end

    task automatic apply_reset(input int n, input bit keep_first);
        exp_t first;
        rst_n      = 1'b0;
        bus.rd_i   = 1'b0;
        if (keep_first && exp_q.size() > 0) begin
            first = exp_q[0];
            exp_q.delete();
            exp_q.push_back(first);
        end else begin
            exp_q.delete();
        end
        repeat (n) exp_q.push_back('{K_RST, 32'd0, 1'b0, 256'd0});
        repeat (n) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 2000) begin
                bad++;
                total++;
                $display("FAIL idle_timeout: model queue still holds %0d entries", exp_q.size());
                $display("test done: total=%0d bad=%0d", total, bad);
                $fatal(1, "model queue never drained");
            end
        end
    endtask

    // mode 0: drop rd_i on ack; 1: hold it one cycle past ack; 2: drop it mid-fill.
    task automatic do_req(input logic [31:0] addr, input int mode, output res_t r);
        int a0, s0, d0;
        wait_idle();
        a0 = ack_cnt;
        s0 = strobe_cnt;
        d0 = rd_cnt;
        addr_log.delete();
        build_fill(addr);
        bus.addr_i = addr;
        bus.rd_i   = 1'b1;
        r.lat   = -1;
        r.fault = 1'bx;
        r.data  = 'x;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk);
            #1;
            if (mode == 2 && n == 3) bus.rd_i = 1'b0;
            if (bus.ack_o === 1'b1) begin
                r.lat   = n;
                r.fault = bus.hw_page_fault_o;
                r.data  = bus.data_o;
                break;
            end
        end
        if (r.lat < 0) begin
            total++;
            bad++;
            $display("FAIL ack_timeout: no ack_o within 400 cycles for addr %h", addr);
        end
        if (mode == 1) begin
            @(posedge clk);
            #1;
        end
        bus.rd_i   = 1'b0;
        bus.addr_i = $urandom;
        wait_idle();
        r.acks    = ack_cnt - a0;
        r.strobes = strobe_cnt - s0;
        r.rds     = rd_cnt - d0;
    endtask

    task automatic do_reset_mid(input logic [31:0] addr, input int beat, output int acks);
        int a0;
        bit found;
        wait_idle();
        a0 = ack_cnt;
        found = 1'b0;
        build_fill(addr);
        bus.addr_i = addr;
        bus.rd_i   = 1'b1;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk);
            #1;
            if (bus.mem_rd_o === 1'b1 && bus.mem_addr_o[4:2] == 3'(beat)) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL beat_timeout: beat %0d never strobed", beat);
        end
        apply_reset(2, 1'b1);
        check("mid_rst_mem_rd", bus.mem_rd_o, 1'b0);
        check("mid_rst_ack", bus.ack_o, 1'b0);
        check("mid_rst_data", bus.data_o, 256'd0);
        wait_idle();
        acks = ack_cnt - a0;
    endtask

    initial begin
        res_t        r;
        int          acks;
        logic [31:0] addr;
        bus.addr_i     = '0;
        bus.rd_i       = 1'b0;
        bus.mem_data_i = '0;
        bus.mem_ack_i  = 1'b0;
        bus.mem_err_i  = 1'b0;
        foreach (waits[k]) waits[k] = 0;
        apply_reset(3, 1'b0);
        check("reset_ack", bus.ack_o, 1'b0);
        check("reset_fault", bus.hw_page_fault_o, 1'b0);
        check("reset_mem_rd", bus.mem_rd_o, 1'b0);
        check("reset_mem_addr", bus.mem_addr_o, 32'd0);
        check("reset_data", bus.data_o, 256'd0);

        do_req(32'h0000_1234, 0, r);
        check("zw_latency", r.lat, 9);
        check("zw_word0", r.data[31:0], 32'hA000_0000);
        check("zw_word7", r.data[255:224], 32'hA000_0007);
        check("zw_fault", r.fault, 1'b0);
        check("zw_acks", r.acks, 1);
        check("zw_beats", addr_log.size(), 8);
        check("zw_first_addr", addr_log[0], 32'h0000_1220);
        check("zw_last_addr", addr_log[7], 32'h0000_123C);

        foreach (waits[k]) waits[k] = 2;
        do_req(32'h0000_5678, 0, r);
        check("ws_latency", r.lat, 25);
        check("ws_acks", r.acks, 1);
        foreach (waits[k]) waits[k] = 0;

        do_req(MEM_LIMIT + 32'd4, 0, r);
        check("rf_latency", r.lat, 1);
        check("rf_no_mem_rd", r.rds, 0);
        check("rf_fault", r.fault, 1'b1);
        check("rf_data", r.data, 256'd0);

        do_req(MEM_LIMIT - 32'd1, 0, r);
        check("edge_fault", r.fault, 1'b0);
        check("edge_latency", r.lat, 9);

        err_en   = 1'b1;
        err_beat = 3;
        do_req(32'h0000_2040, 0, r);
        check("be_strobes", r.strobes, 4);
        check("be_fault", r.fault, 1'b1);
        check("be_data", r.data, 256'd0);
        check("be_acks", r.acks, 1);
        err_en = 1'b0;
        do_req(32'h0000_2040, 0, r);
        check("be_next_fault", r.fault, 1'b0);
        check("be_next_word3", r.data[127:96], 32'hA000_0003);

        do_req(32'h0000_3000, 1, r);
        check("sticky_acks", r.acks, 1);
        do_req(32'h0000_3020, 0, r);
        check("sticky_next_acks", r.acks, 1);
        check("sticky_next_word7", r.data[255:224], 32'hA000_0007);

        do_req(32'h0000_4000, 2, r);
        check("drop_acks", r.acks, 1);
        check("drop_latency", r.lat, 9);

        do_reset_mid(32'h0000_1234, 4, acks);
        check("mid_rst_acks", acks, 0);
        do_req(32'h0000_1234, 0, r);
        check("post_rst_word0", r.data[31:0], 32'hA000_0000);
        check("post_rst_latency", r.lat, 9);

        plan_mem = 1'b0;
        repeat (40) begin
            foreach (waits[k]) waits[k] = $urandom_range(0, 3);
            err_en   = ($urandom_range(0, 4) == 0);
            err_beat = $urandom_range(0, 7);
            if ($urandom_range(0, 5) == 0) addr = MEM_LIMIT + ($urandom & 32'h00FF_FFFF);
            else                           addr = $urandom & (MEM_LIMIT - 32'd1);
            do_req(addr, $urandom_range(0, 2), r);
            check("rand_acks", r.acks, 1);
        end
        err_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
